fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction-fetch front end sitting directly upstream of the IF/ID buffer.
- Owns the fetch PC and issues addresses to instruction memory, which has a 1-cycle read latency.
- Captures the returned words with their PCs in a small prefetch FIFO and presents them, one per cycle, under a valid/stall handshake.
- Takes branch/jump redirects from the writeback-stage PC control, flushing all queued and in-flight fetches.

Parameters:
- DEPTH, 4, prefetch FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- PC_STEP, 32'd1, increment applied to the fetch PC per issued fetch (word addressing).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- out_imem_pc  output  32  fetch address to instruction memory (the fetch_pc register).
- out_imem_req  output  1  fetch issued this cycle (combinational from state).
- in_imem_inst  input  32  instruction word, valid in the cycle after the request.
- in_ctrl_redirect  input  1  taken branch/jump: flush the queue and refetch.
- in_redirect_pc  input  32  redirect target.
- in_ctrl_stall  input  1  downstream not accepting this cycle.
- out_valid  output  1  the head entry is valid.
- out_pc  output  32  PC of the head entry.
- out_inst  output  32  instruction of the head entry.
- out_count  output  $clog2(DEPTH)+1  current number of FIFO entries.

Behaviour:
- Reset (rst_n=0 at an edge):
  - fetch_pc=RESET_PC, pending=0, count=0, read/write pointers=0.
  - out_valid=0, out_pc=0, out_inst=0, out_count=0.
  - out_imem_req=0 while rst_n=0.
  - Reset mid-operation discards all entries and any in-flight fetch; no partial state survives.
- Issue condition:
  - out_imem_req = rst_n & !in_ctrl_redirect & (count + pending < DEPTH).
  - This is conservative: a same-cycle dequeue does not free a slot for issue.
- On an issue edge:
  - pending<=1, pending_pc<=fetch_pc, fetch_pc<=fetch_pc+PC_STEP (mod 2^32; 32'hFFFF_FFFF+1 -> 0).
  - If no issue, pending<=0.
- Response:
  - If pending=1 at an edge with no redirect, {pending_pc, in_imem_inst} is written at wr_ptr and wr_ptr increments.
  - The issue-condition bound guarantees the write never overflows the FIFO.
- Dequeue: at an edge where out_valid & !in_ctrl_stall, rd_ptr increments.
  - Pointers wrap modulo DEPTH.
  - Simultaneous enqueue and dequeue leaves count unchanged.
- Outputs:
  - out_valid = (count != 0).
  - out_pc and out_inst are the registered head entry; they are 0 when empty.
  - While out_valid=1 and in_ctrl_stall=1, out_pc and out_inst hold stable.
- Redirect (in_ctrl_redirect=1 at an edge), highest priority after reset:
  - count<=0 and pointers<=0.
  - pending<=0; any response arriving that edge is dropped.
  - fetch_pc<=in_redirect_pc.
  - No issue occurs in the redirect cycle. The first fetch of the target is issued the next cycle, so the target appears at the output 2 cycles after the redirect edge.
  - Redirect overrides a simultaneous stall, enqueue, or dequeue.
- Latency:
  - Request accepted at edge E, entry written at E+1, out_valid=1 in the cycle after E+1.
  - Sustained throughput is 1 instruction/cycle when the bench never stalls.
- Full: with count=DEPTH, no issue occurs. Issue resumes the cycle after count+pending drops below DEPTH.
- Empty with stall: in_ctrl_stall has no effect.

Test Plan:
- Reset release, imem model returns inst=PC+32'hA000, no stall.
  - Required: out_valid first high 1 cycle after the first request edge.
  - Required: out_pc sequence 0,1,2,3…, out_inst 32'hA000,32'hA001…, one per cycle, with no gaps.
- Hold in_ctrl_stall=1 for 10 cycles.
  - Required: out_count saturates at 4 and out_imem_req drops to 0.
  - Required: head stays at pc=0 throughout.
  - Required: after release, pcs 0..3 drain in order, then fetching resumes at pc=4 with no loss or duplication.
- Redirect to 32'h40 while 3 entries are queued and 1 fetch is in flight.
  - Required: out_valid=0 the next cycle.
  - Required: the next delivered out_pc is 32'h40 and the stale in-flight word never appears.
- Redirect asserted together with stall and a response arrival.
  - Required: queue empties, stall is ignored, and the first output after the redirect has pc=in_redirect_pc.
- RESET_PC=32'hFFFF_FFFE with no stall.
  - Required: out_pc sequence FFFF_FFFE, FFFF_FFFF, 0000_0000, 0000_0001.
- Assert rst_n=0 for one cycle mid-stream with 2 entries queued.
  - Required: out_valid=0 and out_count=0 after the edge.
  - Required: fetching restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch queue, instruction memory and the IF/ID side.
// DEPTH only sizes out_count and must match the fetch_queue instance.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   out_imem_pc;
  logic          out_imem_req;
  logic [31:0]   in_imem_inst;
  logic          in_ctrl_redirect;
  logic [31:0]   in_redirect_pc;
  logic          in_ctrl_stall;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [31:0]   out_inst;
  logic [CW-1:0] out_count;

  modport master (
    output out_imem_pc, out_imem_req,
    input  in_imem_inst,
    input  in_ctrl_redirect, in_redirect_pc, in_ctrl_stall,
    output out_valid, out_pc, out_inst, out_count
  );

  modport slave (
    input  out_imem_pc, out_imem_req,
    output in_imem_inst,
    output in_ctrl_redirect, in_redirect_pc, in_ctrl_stall,
    input  out_valid, out_pc, out_inst, out_count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues to a 1-cycle imem and
// buffers returned words with their PCs in a small prefetch FIFO.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input logic           clk,
  input logic           rst_n,
  fetch_queue_if.master fq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   pending_pc;
  logic          pending;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   inst_q [DEPTH];

  logic issue;
  logic enq;
  logic deq;
  logic empty;

  assign empty = (count == '0);

  // Reserving a slot for the in-flight fetch keeps the response write from
  // ever overflowing; a same-cycle dequeue is deliberately not counted.
  assign issue = rst_n & ~fq.in_ctrl_redirect &
                 ((count + CW'(pending)) < CW'(DEPTH));
  assign enq   = pending & ~fq.in_ctrl_redirect;
  assign deq   = ~empty & ~fq.in_ctrl_stall & ~fq.in_ctrl_redirect;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc   <= RESET_PC;
      pending_pc <= '0;
      pending    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else if (fq.in_ctrl_redirect) begin
      fetch_pc <= fq.in_redirect_pc;
      pending  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      pending <= issue;
      if (issue) begin
        pending_pc <= fetch_pc;
        fetch_pc   <= fetch_pc + PC_STEP;
      end
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && enq) begin
      pc_q[wr_ptr]   <= pending_pc;
      inst_q[wr_ptr] <= fq.in_imem_inst;
    end
  end

  assign fq.out_imem_pc  = fetch_pc;
  assign fq.out_imem_req = issue;
  assign fq.out_valid    = ~empty;
  assign fq.out_pc       = empty ? 32'h0 : pc_q[rd_ptr];
  assign fq.out_inst     = empty ? 32'h0 : inst_q[rd_ptr];
  assign fq.out_count    = count;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] WPC   = 32'hFFFF_FFFE;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  bit   model_ok = 0;
  bit   wdone = 0;

  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH)) ifa ();
  fetch_queue_if #(.DEPTH(DEPTH)) ifw ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC), .PC_STEP(32'd1)) dut (
    .clk(clk), .rst_n(rst_n), .fq(ifa.master));
  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(WPC), .PC_STEP(32'd1)) dut_w (
    .clk(clk), .rst_n(rst_n), .fq(ifw.master));

  // Instruction memory: word at address A is A + 0xA000, one cycle later.
  always @(posedge clk) ifa.in_imem_inst <= ifa.out_imem_pc + 32'hA000;
  always @(posedge clk) ifw.in_imem_inst <= ifw.out_imem_pc + 32'hA000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: what sits in the FIFO (by PC), the fetch in flight, next PC.
  logic [31:0] mq[$];
  bit          infl = 0;
  logic [31:0] infl_pc = '0;
  logic [31:0] mfetch = RPC;
  bit          m_iss;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      infl   = 0;
      mfetch = RPC;
    end else if (ifa.in_ctrl_redirect) begin
      mq.delete();
      infl   = 0;
      mfetch = ifa.in_redirect_pc;
    end else begin
      m_iss = (mq.size() + int'(infl)) < DEPTH;
      if (mq.size() != 0 && !ifa.in_ctrl_stall) void'(mq.pop_front());
      if (infl) mq.push_back(infl_pc);
      infl = m_iss;
      if (m_iss) begin
        infl_pc = mfetch;
        mfetch  = mfetch + 32'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("m_valid", 32'(ifa.out_valid), 32'(mq.size() != 0));
      chk("m_pc", ifa.out_pc, (mq.size() != 0) ? mq[0] : 32'h0);
      chk("m_inst", ifa.out_inst, (mq.size() != 0) ? mq[0] + 32'hA000 : 32'h0);
      chk("m_count", 32'(ifa.out_count), 32'(mq.size()));
      chk("m_req", 32'(ifa.out_imem_req),
          32'(rst_n && !ifa.in_ctrl_redirect && (mq.size() + int'(infl)) < DEPTH));
      chk("m_imem_pc", ifa.out_imem_pc, mfetch);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Wrap-around instance: free-running, checked right after the first release.
  initial begin
    logic [31:0] wexp [4];
    int n;
    wexp[0] = 32'hFFFF_FFFE; wexp[1] = 32'hFFFF_FFFF;
    wexp[2] = 32'h0000_0000; wexp[3] = 32'h0000_0001;
    ifw.in_ctrl_redirect = 1'b0;
    ifw.in_ctrl_stall    = 1'b0;
    ifw.in_redirect_pc   = 32'h0;
    wait (model_ok);
    wait (rst_n === 1'b1);
    @(negedge clk);
    n = 0;
    while (!ifw.out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("wrap_lat", 32'(n), 32'd2);
    for (int k = 0; k < 4; k++) begin
      chk("wrap_valid", 32'(ifw.out_valid), 32'd1);
      chk("wrap_pc", ifw.out_pc, wexp[k]);
      chk("wrap_inst", ifw.out_inst, wexp[k] + 32'hA000);
      @(negedge clk);
    end
    wdone = 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    ifa.in_ctrl_stall    = 1'b0;
    ifa.in_ctrl_redirect = 1'b0;
    ifa.in_redirect_pc   = 32'h0;
    cyc();
    model_ok = 1;
    cyc();
    @(negedge clk);
    chk("rst_valid", 32'(ifa.out_valid), 32'd0);
    chk("rst_count", 32'(ifa.out_count), 32'd0);
    chk("rst_req", 32'(ifa.out_imem_req), 32'd0);
    chk("rst_pc", ifa.out_pc, 32'h0);
    chk("rst_imem_pc", ifa.out_imem_pc, RPC);

    // Streaming with no stall
    cyc(); rst_n = 1'b1;
    @(negedge clk);
    chk("start_req", 32'(ifa.out_imem_req), 32'd1);
    chk("start_valid", 32'(ifa.out_valid), 32'd0);
    cyc(); @(negedge clk);
    chk("lat_valid_early", 32'(ifa.out_valid), 32'd0);
    cyc(); @(negedge clk);
    chk("lat_valid", 32'(ifa.out_valid), 32'd1);
    chk("lat_pc", ifa.out_pc, 32'h0);
    chk("lat_inst", ifa.out_inst, 32'hA000);
    for (int k = 1; k < 6; k++) begin
      cyc(); @(negedge clk);
      chk("seq_valid", 32'(ifa.out_valid), 32'd1);
      chk("seq_pc", ifa.out_pc, 32'(k));
      chk("seq_inst", ifa.out_inst, 32'hA000 + 32'(k));
    end

    // Build two queued entries, then a one-cycle reset mid-stream
    cyc(); ifa.in_ctrl_stall = 1'b1;
    cyc(); rst_n = 1'b0;
    @(negedge clk);
    chk("pre_rst_count", 32'(ifa.out_count), 32'd2);
    cyc(); rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(ifa.out_valid), 32'd0);
    chk("mid_rst_count", 32'(ifa.out_count), 32'd0);
    chk("mid_rst_imem_pc", ifa.out_imem_pc, RPC);
    chk("mid_rst_req", 32'(ifa.out_imem_req), 32'd1);

    // Stall held for 10 cycles from restart
    for (int k = 1; k < 10; k++) begin
      cyc(); @(negedge clk);
      chk("stall_head", ifa.out_pc, 32'h0);
    end
    chk("stall_count", 32'(ifa.out_count), 32'd4);
    chk("stall_req", 32'(ifa.out_imem_req), 32'd0);
    chk("stall_imem_pc", ifa.out_imem_pc, 32'd4);
    cyc(); ifa.in_ctrl_stall = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("drain_valid", 32'(ifa.out_valid), 32'd1);
      chk("drain_pc", ifa.out_pc, 32'(k));
      cyc();
    end

    // Three queued plus one in flight, then redirect to 0x40
    ifa.in_ctrl_stall = 1'b1;
    cyc();
    ifa.in_ctrl_stall    = 1'b0;
    ifa.in_ctrl_redirect = 1'b1;
    ifa.in_redirect_pc   = 32'h40;
    @(negedge clk);
    chk("rd_pre_count", 32'(ifa.out_count), 32'd3);
    cyc(); ifa.in_ctrl_redirect = 1'b0;
    @(negedge clk);
    chk("rd_valid", 32'(ifa.out_valid), 32'd0);
    chk("rd_count", 32'(ifa.out_count), 32'd0);
    chk("rd_imem_pc", ifa.out_imem_pc, 32'h40);
    n = 0;
    while (!ifa.out_valid && n < 10) begin
      cyc(); @(negedge clk);
      n++;
    end
    chk("rd_lat", 32'(n), 32'd2);
    chk("rd_pc", ifa.out_pc, 32'h40);
    chk("rd_inst", ifa.out_inst, 32'hA040);
    for (int k = 1; k < 4; k++) begin
      cyc(); @(negedge clk);
      chk("rd_seq_pc", ifa.out_pc, 32'h40 + 32'(k));
    end

    // Redirect coinciding with stall and a response arrival
    cyc();
    ifa.in_ctrl_redirect = 1'b1;
    ifa.in_ctrl_stall    = 1'b1;
    ifa.in_redirect_pc   = 32'h100;
    @(negedge clk);
    chk("rs_pre_valid", 32'(ifa.out_valid), 32'd1);
    cyc();
    ifa.in_ctrl_redirect = 1'b0;
    ifa.in_ctrl_stall    = 1'b0;
    @(negedge clk);
    chk("rs_valid", 32'(ifa.out_valid), 32'd0);
    chk("rs_count", 32'(ifa.out_count), 32'd0);
    chk("rs_imem_pc", ifa.out_imem_pc, 32'h100);
    n = 0;
    while (!ifa.out_valid && n < 10) begin
      cyc(); @(negedge clk);
      n++;
    end
    chk("rs_lat", 32'(n), 32'd2);
    chk("rs_pc", ifa.out_pc, 32'h100);
    chk("rs_inst", ifa.out_inst, 32'hA100);
    repeat (4) cyc();

    n = 0;
    while (!wdone && n < 100) begin
      cyc();
      n++;
    end
    chk("wrap_done", 32'(wdone), 32'd1);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
